sram_ctrl: RTL
==============

# sram_ctrl

Synchronous initiator that turns single load/store requests from the datapath into correctly sequenced strobes on the asynchronous SRAM pin interface: `cs`, `oe`, `we`, `addr`, `din` and `dout`. It sits between the processor's memory stage and the SRAM model. It guarantees three things on the pins:
- address and write data are stable before any strobe rises;
- strobes are held for a programmable number of cycles;
- read data is registered before it is handed back.

It accepts one request at a time with a valid/ready handshake and returns a one-cycle response pulse.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: cycles the `oe`/`we` strobe is held. Legal range is 1–15; 0 is illegal.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_ready`  out  1  controller can accept a request.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  read data, valid with `rsp_valid` on reads.
- `rsp_err`  out  1  request rejected; valid with `rsp_valid`.
- `sram_cs`  out  1  chip select.
- `sram_oe`  out  1  output enable.
- `sram_we`  out  1  write enable.
- `sram_addr`  out  32  SRAM address.
- `sram_din`  out  32  SRAM write data.
- `sram_dout`  in  32  SRAM read data.

## Operation
- All outputs are registered.
- Reset values: `req_ready` = 0 during reset and 1 on the first cycle after reset deasserts. Every other output is 0 on reset.
- FSM states are IDLE, SETUP, STROBE, DONE.
- **IDLE**
  - `req_ready` = 1 and all SRAM pins are low.
  - `req_valid` = 1 accepts the request (valid && ready): latch `req_we`, `req_addr` and `req_wdata`, then go to SETUP.
- **SETUP** (1 cycle)
  - `sram_cs` = 1; `sram_addr` and `sram_din` driven from the latched values.
  - `sram_oe` = `sram_we` = 0.
  - Go to STROBE with the wait counter loaded to `WAIT_CYCLES`-1.
- **STROBE** (`WAIT_CYCLES` cycles)
  - `sram_cs` = 1, address and data unchanged.
  - Reads drive `sram_oe` = 1; writes drive `sram_we` = 1.
  - The wait counter decrements each cycle. On the cycle it reads 0, reads capture `sram_dout` into `rsp_rdata`, then go to DONE.
- **DONE** (1 cycle)
  - Strobes return to 0 while `sram_cs` stays 1 and the address is held.
  - `rsp_valid` = 1, then go to IDLE.
- `rsp_rdata` holds its value until the next completed read. Writes and errors leave it unchanged.
- `sram_addr` and `sram_din` change only in IDLE→SETUP. They never change while a strobe is high.
- `req_valid` asserted outside IDLE is ignored: `req_ready` is 0 and nothing is latched.
- Reset mid-transaction: the FSM goes to IDLE on that edge and all pins drop to 0. No `rsp_valid` is issued for the aborted request.

## Timing
- Request accepted at edge N: SETUP in cycle N+1, STROBE in cycles N+2 … N+1+W, DONE/`rsp_valid` in cycle N+2+W.
- `req_ready` is high again in cycle N+3+W.
- Throughput is one transaction per W+3 cycles.
- With `req_valid` held high continuously, the next request is accepted at the end of cycle N+3+W.
- Read data is sampled from `sram_dout` in the last STROBE cycle and is visible on `rsp_rdata` from DONE onward.
- No combinational path from any input to any output.

## Configuration
- Macro `SRAM_CTRL_ALIGN_CHECK_EN`.
- **Defined:** a request with `req_addr[1:0]` ≠ 0 is still accepted but skips SETUP and STROBE.
  - All SRAM pins stay 0.
  - The FSM goes IDLE→DONE, with `rsp_valid` = 1 and `rsp_err` = 1 in cycle N+1.
  - Aligned requests behave as above with `rsp_err` = 0.
- **Undefined:** no alignment check. `req_addr` passes to `sram_addr` unmodified and `rsp_err` is tied to 0.

## Test plan
- **Write then read, W=1:** write 0x0000_0010 ← 0xDEAD_BEEF, then read 0x0000_0010.
  - `sram_we` is high for exactly 1 cycle with addr/din stable for SETUP+STROBE+DONE.
  - Read `rsp_valid` arrives 3 cycles after accept with `rsp_rdata` = 0xDEAD_BEEF.
- **W=3 read:** `sram_oe` is high for 3 cycles and `rsp_valid` is at accept+5. Changing `sram_dout` during the first two STROBE cycles does not affect the captured value; only the last-cycle value appears.
- **Back-to-back:** `req_valid` held high with 4 alternating writes/reads. Accepts are spaced exactly W+3 cycles apart, and requests arriving while busy are not latched.
- **Reset mid-write:** assert `reset` during STROBE. All pins are 0 next cycle, no `rsp_valid`, and `req_ready` is 1 the cycle after reset deasserts.
- **Misaligned request, macro defined:** read 0x0000_0012. `rsp_valid` = `rsp_err` = 1 at accept+1, `sram_cs` never rises, and `rsp_rdata` keeps its previous value.
- **Misaligned request, macro undefined:** same read of 0x0000_0012. `sram_addr` = 0x0000_0012 and `rsp_err` = 0.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Request/response handshake plus asynchronous SRAM pin bundle for sram_ctrl.
// The slave modport is the controller's view; master is the datapath/SRAM side.
interface sram_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-request asynchronous SRAM controller: IDLE -> SETUP -> STROBE(xW) -> DONE.
// Define SRAM_CTRL_ALIGN_CHECK_EN to reject word-misaligned requests with rsp_err.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  sram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("sram_ctrl: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        op_we_q, op_we_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        sram_cs_q, sram_cs_d;
  logic        sram_oe_q, sram_oe_d;
  logic        sram_we_q, sram_we_d;
  logic [31:0] sram_addr_q, sram_addr_d;
  logic [31:0] sram_din_q, sram_din_d;

  logic accept;
  logic misaligned;

  assign accept     = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign misaligned = ALIGN_CHECK && (bus.req_addr[1:0] != 2'b00);

  // Every output is a flop, so each branch computes the pin values of the state being entered.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    op_we_d     = op_we_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    sram_cs_d   = 1'b0;
    sram_oe_d   = 1'b0;
    sram_we_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          op_we_d     = bus.req_we;
          if (misaligned) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = SETUP;
            sram_cs_d   = 1'b1;
            sram_addr_d = bus.req_addr;
            sram_din_d  = bus.req_wdata;
          end
        end
      end

      SETUP: begin
        state_d    = STROBE;
        wait_cnt_d = WAIT_LOAD;
        sram_cs_d  = 1'b1;
        sram_oe_d  = ~op_we_q;
        sram_we_d  = op_we_q;
      end

      STROBE: begin
        sram_cs_d = 1'b1;
        if (wait_cnt_q == 4'd0) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          if (!op_we_q) begin
            rsp_rdata_d = bus.sram_dout;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          sram_oe_d  = ~op_we_q;
          sram_we_d  = op_we_q;
        end
      end

      DONE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      op_we_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      sram_cs_q   <= 1'b0;
      sram_oe_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_addr_q <= 32'h0;
      sram_din_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      op_we_q     <= op_we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      sram_cs_q   <= sram_cs_d;
      sram_oe_q   <= sram_oe_d;
      sram_we_q   <= sram_we_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.sram_cs   = sram_cs_q;
  assign bus.sram_oe   = sram_oe_q;
  assign bus.sram_we   = sram_we_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_din  = sram_din_q;

endmodule
